// File: rtl/demux_pkg.sv
// Shared definitions for the 2-channel 7-bit link demultiplexer.
// Framing states and default widths used by the top and channel registers.
package demux_pkg;

    localparam int DEF_P_W      = 7;
    localparam int DEF_P_ERR_CW = 8;

    typedef logic state_t;

    localparam state_t S_EXP0 = 1'b0;
    localparam state_t S_EXP1 = 1'b1;

    // Channel a well-framed word must target in a given state.
    function automatic logic exp_sel(input state_t s);
        return (s == S_EXP1);
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// Per-channel valid/data holding register with one-deep storage.
// space is high when the slot is empty or drains this cycle.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int P_W = DEF_P_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [P_W-1:0] wdata,
    input  logic           ready,
    output logic           valid,
    output logic [P_W-1:0] data,
    output logic           space
);

    assign space = ~valid | ready;

    // Load wins over drain so back-to-back words stream without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= wdata;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_2ch_7bits.sv
// Receive end of the 2:1 time-multiplexed link: routing, framing FSM, errors.
// Optional order checking is enabled by defining DEMUX_ORDER_CHECK_EN.
module demux_2ch_7bits
    import demux_pkg::*;
#(
    parameter int P_W      = DEF_P_W,
    parameter int P_ERR_CW = DEF_P_ERR_CW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_sel,
    input  logic [P_W-1:0]      in_data,
    output logic                in_ready,
    output logic                out0_valid,
    output logic [P_W-1:0]      out0_data,
    input  logic                out0_ready,
    output logic                out1_valid,
    output logic [P_W-1:0]      out1_data,
    input  logic                out1_ready,
    output logic                pair_done,
    output logic                err,
    output logic [P_ERR_CW-1:0] err_cnt
);

    state_t state_q;
    state_t state_d;
    logic   pair_d;
    logic   space0;
    logic   space1;
    logic   sel_space;
    logic   oo;
    logic   acc;
    logic   good;
    logic   load0;
    logic   load1;

`ifdef DEMUX_ORDER_CHECK_EN
    assign oo = (in_sel != exp_sel(state_q));
`else
    assign oo = 1'b0;
`endif

    assign sel_space = in_sel ? space1 : space0;
    assign in_ready  = oo | sel_space;
    assign acc       = in_valid & in_ready;
    assign good      = acc & ~oo;
    assign load0     = good & ~in_sel;
    assign load1     = good & in_sel;

    demux_chan_reg #(.P_W(P_W)) u_ch0 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load0),
        .wdata (in_data),
        .ready (out0_ready),
        .valid (out0_valid),
        .data  (out0_data),
        .space (space0)
    );

    demux_chan_reg #(.P_W(P_W)) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load1),
        .wdata (in_data),
        .ready (out1_ready),
        .valid (out1_valid),
        .data  (out1_data),
        .space (space1)
    );

    // Framing: ch0 opens a pair, ch1 closes it; other words leave state alone.
    always_comb begin
        state_d = state_q;
        pair_d  = 1'b0;
        if (good) begin
            if (!in_sel && state_q == S_EXP0) begin
                state_d = S_EXP1;
            end else if (in_sel && state_q == S_EXP1) begin
                state_d = S_EXP0;
                pair_d  = 1'b1;
            end
        end
    end

    // State register and the registered one-cycle pair pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EXP0;
            pair_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            pair_done <= pair_d;
        end
    end

`ifdef DEMUX_ORDER_CHECK_EN
    logic                bad_acc;
    logic [P_ERR_CW-1:0] cnt_q;

    assign bad_acc = acc & oo;
    assign err_cnt = cnt_q;

    // Sticky error flag and saturating count of dropped out-of-order words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err   <= 1'b0;
            cnt_q <= '0;
        end else if (bad_acc) begin
            err <= 1'b1;
            if (cnt_q != {P_ERR_CW{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_2ch_7bits.sv
// Scoreboard bench for demux_2ch_7bits: directed words, queue-based monitor.
// Build with DEMUX_ORDER_CHECK_EN defined to exercise order checking.
module tb_demux_2ch_7bits;

`ifdef DEMUX_ORDER_CHECK_EN
    localparam bit ORDER_EN = 1'b1;
`else
    localparam bit ORDER_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sel = 1'b0;
    logic [6:0] in_data = '0;
    logic       in_ready;
    logic       out0_valid;
    logic [6:0] out0_data;
    logic       out0_ready = 1'b1;
    logic       out1_valid;
    logic [6:0] out1_data;
    logic       out1_ready = 1'b1;
    logic       pair_done;
    logic       err;
    logic [7:0] err_cnt;

    int vectors = 0;
    int errors = 0;

    logic [6:0] q0[$];
    logic [6:0] q1[$];

    bit m_state = 1'b0;
    bit m_err = 1'b0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    demux_2ch_7bits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .pair_done  (pair_done),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake seen before an edge pops one expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) chk("out0_spurious", out0_valid, 0);
                else chk("out0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) chk("out1_spurious", out1_valid, 0);
                else chk("out1_data", out1_data, q1.pop_front());
            end
        end
    end

    task automatic send(input bit sel, input logic [6:0] d);
        bit bad;
        bit pair;
        int n;
        bad = ORDER_EN && (sel != m_state);
        pair = !bad && sel && m_state;
        in_valid = 1'b1;
        in_sel = sel;
        in_data = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("in_ready_wait", in_ready, 1);
        if (!bad) begin
            if (sel) q1.push_back(d);
            else q0.push_back(d);
            if (!sel && !m_state) m_state = 1'b1;
            else if (sel && m_state) m_state = 1'b0;
        end else begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pair_done", pair_done, pair);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        if (!bad) begin
            if (sel) begin
                chk("out1_valid_lat", out1_valid, 1);
                chk("out1_data_lat", out1_data, d);
            end else begin
                chk("out0_valid_lat", out0_valid, 1);
                chk("out0_data_lat", out0_data, d);
            end
        end
        @(posedge clk);
        #1;
        chk("pair_done_1cyc", pair_done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        #12;
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out0_data", out0_data, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_pair_done", pair_done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T2: routing and latency, one full pair.
        send(1'b0, 7'h3F);
        send(1'b1, 7'h06);

        // T3: backpressure on ch0.
        out0_ready = 1'b0;
        send(1'b0, 7'h5B);
        send(1'b1, 7'h7D);
        in_valid = 1'b1;
        in_sel = 1'b0;
        in_data = 7'h4F;
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_data", out0_data, 7'h5B);
        @(negedge clk);
        chk("bp_hold_data2", out0_data, 7'h5B);
        chk("bp_hold_valid", out0_valid, 1);
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        q0.push_back(7'h4F);
        m_state = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_nobubble_valid", out0_valid, 1);
        chk("bp_new_data", out0_data, 7'h4F);

        // T4: ch1 still accepts while ch0 is stalled full.
        @(posedge clk);
        #1;
        out0_ready = 1'b0;
        send(1'b1, 7'h11);
        send(1'b0, 7'h71);
        in_sel = 1'b0;
        #1;
        chk("ind_ch0_blocked", in_ready, 0);
        send(1'b1, 7'h66);
        chk("ind_ch0_held", out0_data, 7'h71);
        out0_ready = 1'b1;
        @(posedge clk);
        #1;

        // T5/T6: out-of-order ch1 word in S_EXP0.
        send(1'b1, 7'h6D);
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 7'(i));
            if (!ORDER_EN) send(1'b0, 7'(i + 1));
        end

        // T1: asynchronous reset mid-cycle with a word held on ch0.
        if (m_state) send(1'b1, 7'h22);
        out0_ready = 1'b0;
        send(1'b0, 7'h2A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", out0_valid, 0);
        chk("arst_out0_data", out0_data, 0);
        chk("arst_out1_valid", out1_valid, 0);
        chk("arst_pair_done", pair_done, 0);
        chk("arst_err", err, 0);
        chk("arst_err_cnt", err_cnt, 0);
        q0.delete();
        q1.delete();
        m_state = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
        out0_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_no_valid", out0_valid, 0);
        // FSM back in S_EXP0: a ch1 word must not close a pair.
        send(1'b1, 7'h55);
        send(1'b0, 7'h0C);
        send(1'b1, 7'h33);

        repeat (4) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
